riscv_decode_stage: RTL and testbench

Registered RV32I decode stage between the fetch unit and execute. It accepts {instr, pc} under a valid/ready handshake and fully decodes every RV32I opcode, including BRANCH, JAL, JALR, MISC_MEM and SYSTEM (CSR, ECALL, EBREAK, MRET). Decoded control is held in a 2-entry skid buffer, so both sides of the stage are fully registered. A synchronous flush supports branch/trap redirects.

---
 rtl/riscv_decode_stage.sv | 303 ++++++++++++++++++++++++++++++
 tb/tb_riscv_decode_stage.sv | 349 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/riscv_decode_stage.sv
// RV32I decode stage with a 2-entry output skid buffer.
// Ports:
//   clk_i, arstn_i              clock, asynchronous active-low reset
//   flush_i                     drop buffered and incoming instructions
//   in_valid_i/in_ready_o       fetch-side handshake carrying instr_i/pc_i
//   out_valid_o/out_ready_i     execute-side handshake for the head entry
//   pc_o, instr_o, *_sel_o, alu_op_o, mem_*_o, gpr_we_a_o, wb_src_sel_o,
//   illegal_instr_o, branch/jal/jalr_o, csr_op_o, mret/ecall/ebreak_o
//                               decoded control of the head entry
module riscv_decode_stage #(
  parameter int unsigned PC_W          = 32,
  parameter bit          ENABLE_SYSTEM = 1'b1,
  parameter bit          ENABLE_FENCE  = 1'b1
) (
  input  logic            clk_i,
  input  logic            arstn_i,
  input  logic            flush_i,
  input  logic            in_valid_i,
  output logic            in_ready_o,
  input  logic [31:0]     instr_i,
  input  logic [PC_W-1:0] pc_i,
  output logic            out_valid_o,
  input  logic            out_ready_i,
  output logic [PC_W-1:0] pc_o,
  output logic [31:0]     instr_o,
  output logic [1:0]      ex_op_a_sel_o,
  output logic [2:0]      ex_op_b_sel_o,
  output logic [4:0]      alu_op_o,
  output logic            mem_req_o,
  output logic            mem_we_o,
  output logic [2:0]      mem_size_o,
  output logic            gpr_we_a_o,
  output logic [1:0]      wb_src_sel_o,
  output logic            illegal_instr_o,
  output logic            branch_o,
  output logic            jal_o,
  output logic            jalr_o,
  output logic [2:0]      csr_op_o,
  output logic            mret_o,
  output logic            ecall_o,
  output logic            ebreak_o
);

  localparam int unsigned DEPTH = 2;

  localparam logic [6:0] OPC_LOAD     = 7'h03;
  localparam logic [6:0] OPC_MISC_MEM = 7'h0f;
  localparam logic [6:0] OPC_OP_IMM   = 7'h13;
  localparam logic [6:0] OPC_AUIPC    = 7'h17;
  localparam logic [6:0] OPC_STORE    = 7'h23;
  localparam logic [6:0] OPC_OP       = 7'h33;
  localparam logic [6:0] OPC_LUI      = 7'h37;
  localparam logic [6:0] OPC_BRANCH   = 7'h63;
  localparam logic [6:0] OPC_JALR     = 7'h67;
  localparam logic [6:0] OPC_JAL      = 7'h6f;
  localparam logic [6:0] OPC_SYSTEM   = 7'h73;

  localparam logic [1:0] OP_A_RS1     = 2'd0;
  localparam logic [1:0] OP_A_CURR_PC = 2'd1;
  localparam logic [1:0] OP_A_ZERO    = 2'd2;

  localparam logic [2:0] OP_B_RS2   = 3'd0;
  localparam logic [2:0] OP_B_IMM_I = 3'd1;
  localparam logic [2:0] OP_B_IMM_S = 3'd2;
  localparam logic [2:0] OP_B_IMM_U = 3'd3;
  localparam logic [2:0] OP_B_INCR  = 3'd4;

  localparam logic [4:0] ALU_ADD = 5'b00000;
  localparam logic [4:0] ALU_SUB = 5'b01000;
  localparam logic [4:0] ALU_SRA = 5'b01101;

  localparam logic [2:0] LDST_B = 3'b000;

  localparam logic [1:0] WB_EX  = 2'd0;
  localparam logic [1:0] WB_LSU = 2'd1;
  localparam logic [1:0] WB_CSR = 2'd2;

  typedef struct packed {
    logic [PC_W-1:0] pc;
    logic [31:0]     instr;
    logic [1:0]      a_sel;
    logic [2:0]      b_sel;
    logic [4:0]      alu_op;
    logic            mem_req;
    logic            mem_we;
    logic [2:0]      mem_size;
    logic            gpr_we;
    logic [1:0]      wb_sel;
    logic            illegal;
    logic            branch;
    logic            jal;
    logic            jalr;
    logic [2:0]      csr_op;
    logic            mret;
    logic            ecall;
    logic            ebreak;
  } entry_t;

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic       illegal;
  entry_t     dec;

  assign opcode = instr_i[6:0];
  assign funct3 = instr_i[14:12];
  assign funct7 = instr_i[31:25];

  // Combinational decode of the incoming instruction.
  always_comb begin
    dec          = '0;
    illegal      = 1'b0;
    dec.pc       = pc_i;
    dec.instr    = instr_i;
    dec.a_sel    = OP_A_RS1;
    dec.b_sel    = OP_B_RS2;
    dec.alu_op   = ALU_ADD;
    dec.mem_size = LDST_B;
    dec.wb_sel   = WB_EX;
    case (opcode)
      OPC_LOAD: begin
        dec.mem_req  = 1'b1;
        dec.mem_size = funct3;
        dec.wb_sel   = WB_LSU;
        dec.gpr_we   = 1'b1;
        dec.b_sel    = OP_B_IMM_I;
        if (funct3 == 3'b011 || funct3[2:1] == 2'b11) illegal = 1'b1;
      end
      OPC_STORE: begin
        dec.mem_req  = 1'b1;
        dec.mem_we   = 1'b1;
        dec.mem_size = funct3;
        dec.b_sel    = OP_B_IMM_S;
        if (funct3[2] || funct3 == 3'b011) illegal = 1'b1;
      end
      OPC_OP_IMM: begin
        dec.b_sel  = OP_B_IMM_I;
        dec.gpr_we = 1'b1;
        dec.alu_op = {2'b00, funct3};
        if (funct3 == 3'b001 && funct7 != 7'h00) illegal = 1'b1;
        if (funct3 == 3'b101) begin
          if (funct7 == 7'h20)      dec.alu_op = ALU_SRA;
          else if (funct7 != 7'h00) illegal = 1'b1;
        end
      end
      OPC_OP: begin
        dec.gpr_we = 1'b1;
        dec.alu_op = {2'b00, funct3};
        if (funct7 == 7'h20) begin
          if (funct3 == 3'b000)      dec.alu_op = ALU_SUB;
          else if (funct3 == 3'b101) dec.alu_op = ALU_SRA;
          else                       illegal = 1'b1;
        end else if (funct7 != 7'h00) begin
          illegal = 1'b1;
        end
      end
      OPC_LUI: begin
        dec.a_sel  = OP_A_ZERO;
        dec.b_sel  = OP_B_IMM_U;
        dec.gpr_we = 1'b1;
      end
      OPC_AUIPC: begin
        dec.a_sel  = OP_A_CURR_PC;
        dec.b_sel  = OP_B_IMM_U;
        dec.gpr_we = 1'b1;
      end
      OPC_BRANCH: begin
        dec.alu_op = {2'b11, funct3};
        dec.b_sel  = OP_B_RS2;
        dec.branch = 1'b1;
        if (funct3[2:1] == 2'b01) illegal = 1'b1;
      end
      OPC_JAL: begin
        dec.jal    = 1'b1;
        dec.a_sel  = OP_A_CURR_PC;
        dec.b_sel  = OP_B_INCR;
        dec.gpr_we = 1'b1;
      end
      OPC_JALR: begin
        dec.jalr   = 1'b1;
        dec.a_sel  = OP_A_CURR_PC;
        dec.b_sel  = OP_B_INCR;
        dec.gpr_we = 1'b1;
        if (funct3 != 3'b000) illegal = 1'b1;
      end
      OPC_MISC_MEM: begin
        // FENCE retires as a NOP; FENCE.I and friends are not supported.
        if (!ENABLE_FENCE || funct3 != 3'b000) illegal = 1'b1;
      end
      OPC_SYSTEM: begin
        if (!ENABLE_SYSTEM) begin
          illegal = 1'b1;
        end else if (funct3 == 3'b000) begin
          case (instr_i)
            32'h0000_0073: dec.ecall  = 1'b1;
            32'h0010_0073: dec.ebreak = 1'b1;
            32'h3020_0073: dec.mret   = 1'b1;
            default:       illegal    = 1'b1;
          endcase
        end else if (funct3 == 3'b100) begin
          illegal = 1'b1;
        end else begin
          dec.csr_op = funct3;
          dec.gpr_we = 1'b1;
          dec.wb_sel = WB_CSR;
        end
      end
      default: illegal = 1'b1;
    endcase
    // Illegal encodings must not cause any side effect downstream.
    if (illegal) begin
      dec.a_sel    = OP_A_RS1;
      dec.b_sel    = OP_B_RS2;
      dec.alu_op   = ALU_ADD;
      dec.mem_req  = 1'b0;
      dec.mem_we   = 1'b0;
      dec.mem_size = LDST_B;
      dec.gpr_we   = 1'b0;
      dec.wb_sel   = WB_EX;
      dec.branch   = 1'b0;
      dec.jal      = 1'b0;
      dec.jalr     = 1'b0;
      dec.csr_op   = 3'b000;
      dec.mret     = 1'b0;
      dec.ecall    = 1'b0;
      dec.ebreak   = 1'b0;
    end
    dec.illegal = illegal;
  end

  entry_t     buf_q [DEPTH];
  logic       head_q;
  logic       tail_q;
  logic [1:0] count_q;
  logic [1:0] count_d;
  logic       in_ready_q;
  logic       out_valid_q;
  logic       push;
  logic       pop;

  assign push = in_valid_i && in_ready_q;
  assign pop  = out_valid_q && out_ready_i;

  // Occupancy after this edge; flush wins over push and pop.
  always_comb begin
    count_d = count_q;
    if (flush_i)           count_d = 2'd0;
    else if (push && !pop) count_d = count_q + 2'd1;
    else if (pop && !push) count_d = count_q - 2'd1;
  end

  // Skid buffer storage and pointers; ready/valid are registered from count_d.
  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      buf_q[0]    <= '0;
      buf_q[1]    <= '0;
      head_q      <= 1'b0;
      tail_q      <= 1'b0;
      count_q     <= 2'd0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      count_q     <= count_d;
      in_ready_q  <= (count_d != 2'd2);
      out_valid_q <= (count_d != 2'd0);
      if (flush_i) begin
        head_q <= 1'b0;
        tail_q <= 1'b0;
      end else begin
        if (push) begin
          buf_q[tail_q] <= dec;
          tail_q        <= ~tail_q;
        end
        if (pop) head_q <= ~head_q;
      end
    end
  end

  entry_t head;
  assign head = buf_q[head_q];

  assign in_ready_o      = in_ready_q;
  assign out_valid_o     = out_valid_q;
  assign pc_o            = head.pc;
  assign instr_o         = head.instr;
  assign ex_op_a_sel_o   = head.a_sel;
  assign ex_op_b_sel_o   = head.b_sel;
  assign alu_op_o        = head.alu_op;
  assign mem_req_o       = head.mem_req;
  assign mem_we_o        = head.mem_we;
  assign mem_size_o      = head.mem_size;
  assign gpr_we_a_o      = head.gpr_we;
  assign wb_src_sel_o    = head.wb_sel;
  assign illegal_instr_o = head.illegal;
  assign branch_o        = head.branch;
  assign jal_o           = head.jal;
  assign jalr_o          = head.jalr;
  assign csr_op_o        = head.csr_op;
  assign mret_o          = head.mret;
  assign ecall_o         = head.ecall;
  assign ebreak_o        = head.ebreak;

endmodule

// File: tb/tb_riscv_decode_stage.sv
// Directed + randomized bench for riscv_decode_stage with a queue-based model.
module tb_riscv_decode_stage;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [1:0]  a_sel;
    logic [2:0]  b_sel;
    logic [4:0]  alu;
    logic        mem_req;
    logic        mem_we;
    logic [2:0]  mem_size;
    logic        gpr_we;
    logic [1:0]  wb;
    logic        illegal;
    logic        branch;
    logic        jal;
    logic        jalr;
    logic [2:0]  csr_op;
    logic        mret;
    logic        ecall;
    logic        ebreak;
  } dec_t;

  logic        clk = 1'b0;
  logic        arstn;
  logic        flush;
  logic        in_valid;
  logic        out_ready;
  logic [31:0] instr;
  logic [31:0] pc;

  logic a_in_ready, a_out_valid, n_in_ready, n_out_valid;
  logic [31:0] a_pc, a_instr, n_pc, n_instr;
  logic [1:0]  a_asel, n_asel, a_wb, n_wb;
  logic [2:0]  a_bsel, n_bsel, a_size, n_size, a_csr, n_csr;
  logic [4:0]  a_alu, n_alu;
  logic a_mreq, a_mwe, a_gwe, a_ill, a_br, a_jal, a_jalr, a_mret, a_ecall, a_ebreak;
  logic n_mreq, n_mwe, n_gwe, n_ill, n_br, n_jal, n_jalr, n_mret, n_ecall, n_ebreak;

  dec_t a_obs, n_obs;
  assign a_obs = {a_pc, a_instr, a_asel, a_bsel, a_alu, a_mreq, a_mwe, a_size, a_gwe, a_wb,
                  a_ill, a_br, a_jal, a_jalr, a_csr, a_mret, a_ecall, a_ebreak};
  assign n_obs = {n_pc, n_instr, n_asel, n_bsel, n_alu, n_mreq, n_mwe, n_size, n_gwe, n_wb,
                  n_ill, n_br, n_jal, n_jalr, n_csr, n_mret, n_ecall, n_ebreak};

  always #5 clk = ~clk;

  riscv_decode_stage #(.PC_W(32), .ENABLE_SYSTEM(1'b1), .ENABLE_FENCE(1'b1)) u_dut (
    .clk_i(clk), .arstn_i(arstn), .flush_i(flush), .in_valid_i(in_valid),
    .in_ready_o(a_in_ready), .instr_i(instr), .pc_i(pc), .out_valid_o(a_out_valid),
    .out_ready_i(out_ready), .pc_o(a_pc), .instr_o(a_instr), .ex_op_a_sel_o(a_asel),
    .ex_op_b_sel_o(a_bsel), .alu_op_o(a_alu), .mem_req_o(a_mreq), .mem_we_o(a_mwe),
    .mem_size_o(a_size), .gpr_we_a_o(a_gwe), .wb_src_sel_o(a_wb), .illegal_instr_o(a_ill),
    .branch_o(a_br), .jal_o(a_jal), .jalr_o(a_jalr), .csr_op_o(a_csr), .mret_o(a_mret),
    .ecall_o(a_ecall), .ebreak_o(a_ebreak)
  );

  riscv_decode_stage #(.PC_W(32), .ENABLE_SYSTEM(1'b0), .ENABLE_FENCE(1'b1)) u_dut_nosys (
    .clk_i(clk), .arstn_i(arstn), .flush_i(flush), .in_valid_i(in_valid),
    .in_ready_o(n_in_ready), .instr_i(instr), .pc_i(pc), .out_valid_o(n_out_valid),
    .out_ready_i(out_ready), .pc_o(n_pc), .instr_o(n_instr), .ex_op_a_sel_o(n_asel),
    .ex_op_b_sel_o(n_bsel), .alu_op_o(n_alu), .mem_req_o(n_mreq), .mem_we_o(n_mwe),
    .mem_size_o(n_size), .gpr_we_a_o(n_gwe), .wb_src_sel_o(n_wb), .illegal_instr_o(n_ill),
    .branch_o(n_br), .jal_o(n_jal), .jalr_o(n_jalr), .csr_op_o(n_csr), .mret_o(n_mret),
    .ecall_o(n_ecall), .ebreak_o(n_ebreak)
  );

  int   checks = 0;
  int   failures = 0;
  dec_t q_sys[$];
  dec_t q_nos[$];
  bit   zero_expected;

  // Reference decode: legality first, then the effects of each instruction class.
  function automatic dec_t ref_decode(input logic [31:0] ins, input logic [31:0] ipc,
                                      input bit en_sys);
    dec_t        e;
    bit          ok;
    logic [6:0]  op;
    logic [2:0]  f3;
    logic [6:0]  f7;
    op = ins[6:0];
    f3 = ins[14:12];
    f7 = ins[31:25];
    e  = '0;
    ok = (ins[1:0] == 2'b11);
    case (op)
      7'h03: begin
        ok = ok && (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
        e.mem_req = 1; e.mem_size = f3; e.wb = 2'd1; e.gpr_we = 1; e.b_sel = 3'd1;
      end
      7'h23: begin
        ok = ok && (f3 inside {3'd0, 3'd1, 3'd2});
        e.mem_req = 1; e.mem_we = 1; e.mem_size = f3; e.b_sel = 3'd2;
      end
      7'h13: begin
        if (f3 == 3'd1) ok = ok && (f7 == 7'h00);
        if (f3 == 3'd5) ok = ok && (f7 inside {7'h00, 7'h20});
        e.alu = (f3 == 3'd5 && f7 == 7'h20) ? 5'd13 : {2'b00, f3};
        e.b_sel = 3'd1; e.gpr_we = 1;
      end
      7'h33: begin
        ok = ok && ((f7 == 7'h00) || (f7 == 7'h20 && (f3 inside {3'd0, 3'd5})));
        e.alu = (f7 == 7'h20) ? {2'b01, f3} : {2'b00, f3};
        e.gpr_we = 1;
      end
      7'h37: begin e.a_sel = 2'd2; e.b_sel = 3'd3; e.gpr_we = 1; end
      7'h17: begin e.a_sel = 2'd1; e.b_sel = 3'd3; e.gpr_we = 1; end
      7'h63: begin
        ok = ok && !(f3 inside {3'd2, 3'd3});
        e.alu = {2'b11, f3}; e.branch = 1;
      end
      7'h6f: begin e.jal = 1; e.a_sel = 2'd1; e.b_sel = 3'd4; e.gpr_we = 1; end
      7'h67: begin
        ok = ok && (f3 == 3'd0);
        e.jalr = 1; e.a_sel = 2'd1; e.b_sel = 3'd4; e.gpr_we = 1;
      end
      7'h0f: ok = ok && (f3 == 3'd0);
      7'h73: begin
        if (!en_sys) ok = 0;
        else if (ins == 32'h0000_0073) e.ecall = 1;
        else if (ins == 32'h0010_0073) e.ebreak = 1;
        else if (ins == 32'h3020_0073) e.mret = 1;
        else if (f3 == 3'd0 || f3 == 3'd4) ok = 0;
        else begin e.csr_op = f3; e.gpr_we = 1; e.wb = 2'd2; end
      end
      default: ok = 0;
    endcase
    if (!ok) e = '0;
    e.illegal = !ok;
    e.pc      = ipc;
    e.instr   = ins;
    return e;
  endfunction

  // Random legal RV32I instruction with random register/immediate fields.
  function automatic logic [31:0] gen_legal();
    logic [31:0] r;
    logic [2:0]  f3;
    logic [31:0] ins;
    int unsigned ld_f3 [5] = '{0, 1, 2, 4, 5};
    int unsigned br_f3 [6] = '{0, 1, 4, 5, 6, 7};
    int unsigned cs_f3 [6] = '{1, 2, 3, 5, 6, 7};
    r = $urandom;
    case ($urandom_range(0, 10))
      0: begin f3 = 3'(ld_f3[$urandom_range(0, 4)]); ins = {r[31:15], f3, r[11:7], 7'h03}; end
      1: begin f3 = 3'($urandom_range(0, 2)); ins = {r[31:15], f3, r[11:7], 7'h23}; end
      2: begin
        f3 = 3'($urandom_range(0, 7));
        if (f3 == 3'd1)      ins = {7'h00, r[24:15], f3, r[11:7], 7'h13};
        else if (f3 == 3'd5) ins = {(r[30] ? 7'h20 : 7'h00), r[24:15], f3, r[11:7], 7'h13};
        else                 ins = {r[31:15], f3, r[11:7], 7'h13};
      end
      3: begin
        f3 = 3'($urandom_range(0, 7));
        ins = {((f3 == 3'd0 || f3 == 3'd5) && r[30]) ? 7'h20 : 7'h00, r[24:15], f3, r[11:7], 7'h33};
      end
      4: ins = {r[31:7], 7'h37};
      5: ins = {r[31:7], 7'h17};
      6: begin f3 = 3'(br_f3[$urandom_range(0, 5)]); ins = {r[31:15], f3, r[11:7], 7'h63}; end
      7: ins = {r[31:7], 7'h6f};
      8: ins = {r[31:15], 3'b000, r[11:7], 7'h67};
      9: begin f3 = 3'(cs_f3[$urandom_range(0, 5)]); ins = {r[31:15], f3, r[11:7], 7'h73}; end
      default: ins = 32'h0000_000f;
    endcase
    return ins;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Compare both instances against the model queues.
  task automatic check_outputs(input string tag);
    chk({tag, ".in_ready"}, 32'(a_in_ready), 32'(q_sys.size() < 2));
    chk({tag, ".out_valid"}, 32'(a_out_valid), 32'(q_sys.size() != 0));
    chk({tag, ".ns_out_valid"}, 32'(n_out_valid), 32'(q_nos.size() != 0));
    if (q_sys.size() != 0 || zero_expected) begin
      dec_t es, en;
      es = (q_sys.size() != 0) ? q_sys[0] : '0;
      en = (q_nos.size() != 0) ? q_nos[0] : '0;
      checks++;
      assert (a_obs === es) else begin
        failures++;
        $error("FAIL %s.entry observed=%h expected=%h", tag, a_obs, es);
      end
      checks++;
      assert (n_obs === en) else begin
        failures++;
        $error("FAIL %s.ns_entry observed=%h expected=%h", tag, n_obs, en);
      end
    end
  endtask

  // One clock: model the handshake, step the queues, then check.
  task automatic cycle(input string tag);
    bit push_m, pop_m;
    push_m = in_valid && (q_sys.size() < 2);
    pop_m  = out_ready && (q_sys.size() != 0);
    @(posedge clk);
    if (flush) begin
      q_sys.delete();
      q_nos.delete();
    end else begin
      if (pop_m) begin
        void'(q_sys.pop_front());
        void'(q_nos.pop_front());
      end
      if (push_m) begin
        q_sys.push_back(ref_decode(instr, pc, 1'b1));
        q_nos.push_back(ref_decode(instr, pc, 1'b0));
        zero_expected = 0;
      end
    end
    #1;
    check_outputs(tag);
  endtask

  initial begin
    arstn = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    instr = 32'h0; pc = 32'h0;
    zero_expected = 1;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check_outputs("reset");
    arstn = 1'b1;
    cycle("post_reset");

    // addi x1,x0,5
    instr = 32'h0050_0093; pc = 32'h100; in_valid = 1; out_ready = 1;
    cycle("addi");
    chk("addi.valid", 32'(a_out_valid), 32'd1);
    chk("addi.alu", 32'(a_alu), 32'd0);
    chk("addi.bsel", 32'(a_bsel), 32'd1);
    chk("addi.gpr_we", 32'(a_gwe), 32'd1);
    chk("addi.illegal", 32'(a_ill), 32'd0);
    chk("addi.pc", a_pc, 32'h100);
    in_valid = 0;
    cycle("addi_drain");

    // Fill with out_ready low, third push stalls
    out_ready = 0; in_valid = 1;
    instr = 32'h0000_a103; pc = 32'h104; cycle("lw_push");
    instr = 32'h0000_0063; pc = 32'h108; cycle("beq_push");
    chk("full.in_ready", 32'(a_in_ready), 32'd0);
    instr = 32'h0000_3003; pc = 32'h10c; cycle("stall1");
    cycle("stall2");
    chk("lw.mem_req", 32'(a_mreq), 32'd1);
    chk("lw.size", 32'(a_size), 32'd2);
    chk("lw.wb", 32'(a_wb), 32'd1);
    out_ready = 1;
    cycle("beq_head");
    chk("beq.branch", 32'(a_br), 32'd1);
    chk("beq.alu", 32'(a_alu), 32'h18);
    cycle("bad_head");
    chk("bad.illegal", 32'(a_ill), 32'd1);
    chk("bad.mem_req", 32'(a_mreq), 32'd0);
    chk("bad.pc", a_pc, 32'h10c);
    in_valid = 0;
    cycle("bad_drain");

    // CSR and MRET, with and without SYSTEM support
    out_ready = 0; in_valid = 1;
    instr = 32'h3402_9073; pc = 32'h200; cycle("csr_push");
    instr = 32'h3020_0073; pc = 32'h204; cycle("mret_push");
    in_valid = 0;
    chk("csr.op", 32'(a_csr), 32'd1);
    chk("csr.wb", 32'(a_wb), 32'd2);
    chk("csr.gpr_we", 32'(a_gwe), 32'd1);
    chk("ns_csr.illegal", 32'(n_ill), 32'd1);
    chk("ns_csr.gpr_we", 32'(n_gwe), 32'd0);
    out_ready = 1;
    cycle("mret_head");
    chk("mret.mret", 32'(a_mret), 32'd1);
    chk("mret.gpr_we", 32'(a_gwe), 32'd0);
    chk("ns_mret.illegal", 32'(n_ill), 32'd1);
    chk("ns_mret.mret", 32'(n_mret), 32'd0);
    cycle("sys_drain");

    // Flush with a full buffer and a pending push
    out_ready = 0; in_valid = 1;
    instr = gen_legal(); pc = 32'h300; cycle("fl_push0");
    instr = gen_legal(); pc = 32'h304; cycle("fl_push1");
    instr = 32'h0050_0093; pc = 32'h308; flush = 1;
    cycle("flush");
    chk("flush.out_valid", 32'(a_out_valid), 32'd0);
    chk("flush.in_ready", 32'(a_in_ready), 32'd1);
    flush = 0; in_valid = 0; out_ready = 1;
    repeat (3) cycle("post_flush");

    // Streaming: one instruction per cycle
    in_valid = 1; out_ready = 1;
    for (int i = 0; i < 20; i++) begin
      instr = gen_legal(); pc = 32'h400 + 32'(i * 4);
      cycle("stream");
      chk("stream.in_ready", 32'(a_in_ready), 32'd1);
      chk("stream.out_valid", 32'(a_out_valid), 32'd1);
      chk("stream.pc", a_pc, pc);
    end
    in_valid = 0;
    cycle("stream_drain");

    // Random traffic including arbitrary encodings and occasional flush
    for (int i = 0; i < 300; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      flush     = ($urandom_range(0, 15) == 0);
      instr     = ($urandom_range(0, 1) == 0) ? gen_legal() : $urandom;
      pc        = $urandom;
      cycle("random");
    end
    flush = 0; in_valid = 0;

    // Asynchronous reset with two entries held
    out_ready = 0; in_valid = 1;
    instr = gen_legal(); pc = 32'h500; cycle("rst_push0");
    instr = gen_legal(); pc = 32'h504; cycle("rst_push1");
    in_valid = 0;
    #2;
    arstn = 1'b0;
    #1;
    q_sys.delete();
    q_nos.delete();
    zero_expected = 1;
    check_outputs("async_reset");
    @(posedge clk);
    #1;
    check_outputs("in_reset");
    arstn = 1'b1;
    cycle("after_reset0");
    cycle("after_reset1");
    in_valid = 1; out_ready = 1; instr = 32'h0000_0073; pc = 32'h600;
    cycle("ecall_push");
    chk("ecall.ecall", 32'(a_ecall), 32'd1);
    in_valid = 0;
    cycle("final_drain");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
